// File: rtl/rr_grant_arbiter.sv
// ============================================================================
// rr_grant_arbiter
//
// Round-robin arbiter for N requesters sharing one resource. A grant is
// registered, one-hot, and held until the resource consumer pulses ack (or the
// requester withdraws). On ack the priority pointer rotates past the winner and
// a new winner is chosen on the same edge, so back-to-back grants are possible.
//
// Optional feature (compile-time macro RR_ARB_TIMEOUT_EN):
//   When defined, a hold counter revokes a grant that has gone TIMEOUT cycles
//   without ack, advancing the pointer exactly as an ack would and pulsing
//   'timeout' for one cycle. When undefined no counter is built and 'timeout'
//   is constant 0.
//
// Parameters:
//   N        number of requesters (2..32)
//   IDW      width of gnt_id, derived from N (do not override)
//   TIMEOUT  max hold cycles without ack (2..65535), timeout build only
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   [N]   request vector, bit i = requester i
//   ack        in   resource finished the current grant (ignored when idle)
//   gnt        out  [N]   registered one-hot grant, zero when idle
//   gnt_valid  out  registered, equals |gnt
//   gnt_id     out  [IDW] binary index of the granted requester, 0 when idle
//   ptr        out  [N]   one-hot priority pointer (set bit = highest priority)
//   timeout    out  one-cycle pulse after a grant is revoked by timeout
// ============================================================================
module rr_grant_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           ack,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   ptr,
    output logic           timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Elaboration-time parameter range checks.
    if (N < 2 || N > 32) begin : g_bad_n
        $error("rr_grant_arbiter: N must be in 2..32");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("rr_grant_arbiter: TIMEOUT must be in 2..65535");
    end

    // First set bit of r scanning upward from the one-hot position p, wrapping.
    // The outer loop selects the start position so every index is a constant.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [N-1:0] p);
        logic [N-1:0] res;
        logic         found;
        res   = '0;
        found = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (p[s]) begin
                for (int o = 0; o < N; o++) begin
                    if (!found && r[(s + o) % N]) begin
                        res[(s + o) % N] = 1'b1;
                        found            = 1'b1;
                    end
                end
            end
        end
        return res;
    endfunction

    // One-hot to binary index; zero vector maps to 0.
    function automatic logic [IDW-1:0] onehot_to_idx(input logic [N-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = idx | IDW'(i);
            end
        end
        return idx;
    endfunction

    state_t           state_r,   state_n_s;
    logic [N-1:0]     gnt_r,     gnt_n_s;
    logic [N-1:0]     ptr_r,     ptr_n_s;
    logic [IDW-1:0]   gnt_id_r;
    logic             gnt_valid_r;
    logic             timeout_r, timeout_n_s;

    logic [N-1:0]     rot_s;        // pointer candidate: winner moved to lowest priority
    logic [N-1:0]     pick_ptr_s;   // winner under the current pointer
    logic [N-1:0]     pick_rot_s;   // winner under the rotated pointer
    logic             req_held_s;   // granted requester still requesting
    logic             expire_s;     // hold budget exhausted this cycle

    assign rot_s      = {gnt_r[N-2:0], gnt_r[N-1]};
    assign pick_ptr_s = rr_pick(req, ptr_r);
    assign pick_rot_s = rr_pick(req, rot_s);
    assign req_held_s = |(req & gnt_r);

`ifdef RR_ARB_TIMEOUT_EN
    logic [15:0] hold_cnt_r, hold_cnt_n_s;

    assign expire_s = (state_r == ST_GRANT) && (hold_cnt_r == 16'(TIMEOUT - 1));

    // Hold counter: counts only while a grant is being held; every other
    // outcome (new load, ack, withdrawal, expiry, idle) leaves it at zero.
    always_comb begin
        hold_cnt_n_s = 16'd0;
        if (state_r == ST_GRANT && !ack && req_held_s && !expire_s) begin
            hold_cnt_n_s = hold_cnt_r + 16'd1;
        end else begin
            hold_cnt_n_s = 16'd0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= 16'd0;
        end else begin
            hold_cnt_r <= hold_cnt_n_s;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Next-state, next-grant and next-pointer decisions.
    always_comb begin
        state_n_s   = state_r;
        gnt_n_s     = gnt_r;
        ptr_n_s     = ptr_r;
        timeout_n_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    gnt_n_s   = pick_ptr_s;
                    state_n_s = ST_GRANT;
                end else begin
                    gnt_n_s   = '0;
                    state_n_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // ack outranks withdrawal; expiry is only reachable while the
                // requester is still holding the grant.
                if (ack || (req_held_s && expire_s)) begin
                    ptr_n_s     = rot_s;
                    gnt_n_s     = pick_rot_s;
                    state_n_s   = (|pick_rot_s) ? ST_GRANT : ST_IDLE;
                    timeout_n_s = !ack;
                end else if (!req_held_s) begin
                    gnt_n_s   = '0;
                    state_n_s = ST_IDLE;
                end else begin
                    gnt_n_s   = gnt_r;
                    state_n_s = ST_GRANT;
                end
            end
            default: begin
                gnt_n_s   = '0;
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; gnt, gnt_id and gnt_valid move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gnt_r       <= '0;
            gnt_id_r    <= '0;
            gnt_valid_r <= 1'b0;
            ptr_r       <= {{(N-1){1'b0}}, 1'b1};
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            gnt_r       <= gnt_n_s;
            gnt_id_r    <= onehot_to_idx(gnt_n_s);
            gnt_valid_r <= |gnt_n_s;
            ptr_r       <= ptr_n_s;
            timeout_r   <= timeout_n_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_id    = gnt_id_r;
    assign ptr       = ptr_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios followed by
// randomized traffic, all compared against an index-based reference model.
module tb_rr_grant_arbiter;

    localparam int N       = 4;
    localparam int IDW     = $clog2(N);
    localparam int TIMEOUT = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic           ack;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   ptr;
    logic           timeout;

    int n_cmp;
    int n_err;

    // Reference model state: granted index (-1 = idle), pointer index,
    // hold count, timeout pulse.
    int m_g;
    int m_p;
    int m_c;
    bit m_t;

    rr_grant_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .ptr       (ptr),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Round-robin choice: first requesting index at or after p, wrapping.
    function automatic int m_pick(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) begin
            if (r[(p + o) % N]) return (p + o) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input logic r_rst, input logic [N-1:0] r_req, input logic r_ack);
        m_t = 1'b0;
        if (r_rst) begin
            m_g = -1; m_p = 0; m_c = 0;
        end else if (m_g < 0) begin
            m_c = 0;
            if (r_req != '0) m_g = m_pick(r_req, m_p);
        end else if (r_ack) begin
            m_p = (m_g + 1) % N;
            m_g = m_pick(r_req, m_p);
            m_c = 0;
        end else if (!r_req[m_g]) begin
            m_g = -1; m_c = 0;
        end else if (TMO_EN && m_c == TIMEOUT - 1) begin
            m_p = (m_g + 1) % N;
            m_g = m_pick(r_req, m_p);
            m_c = 0;
            m_t = 1'b1;
        end else begin
            m_c = m_c + 1;
        end
    endtask

    task automatic compare_all();
        check("gnt",       32'(gnt),       (m_g < 0) ? 32'd0 : (32'd1 << m_g));
        check("gnt_valid", 32'(gnt_valid), (m_g < 0) ? 32'd0 : 32'd1);
        check("gnt_id",    32'(gnt_id),    (m_g < 0) ? 32'd0 : 32'(m_g));
        check("ptr",       32'(ptr),       32'd1 << m_p);
        check("timeout",   32'(timeout),   32'(m_t));
    endtask

    task automatic step(input logic r_rst, input logic [N-1:0] r_req, input logic r_ack);
        rst = r_rst; req = r_req; ack = r_ack;
        @(posedge clk);
        model_update(r_rst, r_req, r_ack);
        #1;
        compare_all();
    endtask

    logic [N-1:0] seq_exp [5];
    logic [N-1:0] cur_req;
    logic         cur_ack;
    logic         cur_rst;

    initial begin
        n_cmp = 0; n_err = 0;
        m_g = -1; m_p = 0; m_c = 0; m_t = 1'b0;
        rst = 1'b1; req = '0; ack = 1'b0;
        #1;

        // Reset state.
        step(1'b1, 4'b0000, 1'b0);
        check("rst_ptr", 32'(ptr), 32'd1);
        check("rst_gnt", 32'(gnt), 32'd0);

        // Full request with ack every cycle: strict rotation.
        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
        seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b1);
            check("rot_gnt", 32'(gnt), 32'(seq_exp[i]));
            check("rot_id", 32'(gnt_id), 32'(i % N));
        end

        // Hold without ack, then ack with a new request pattern.
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0100, 1'b0);
            if (!TMO_EN) check("hold_gnt", 32'(gnt), 32'h4);
        end
        step(1'b0, 4'b0110, 1'b1);
        if (!TMO_EN) check("after_hold_gnt", 32'(gnt), 32'h2);

        // Two requesters at opposite ends of the pointer range.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1001, 1'b0);
        check("r1001_first", 32'(gnt), 32'h1);
        step(1'b0, 4'b1001, 1'b1);
        check("r1001_second", 32'(gnt), 32'h8);
        check("r1001_ptr1", 32'(ptr), 32'h2);
        step(1'b0, 4'b1001, 1'b1);
        check("r1001_ptr2", 32'(ptr), 32'h1);

        // Withdrawal without ack, then reset while granted.
        step(1'b0, 4'b0000, 1'b0);
        check("withdraw_valid", 32'(gnt_valid), 32'd0);
        check("withdraw_ptr", 32'(ptr), 32'h1);
        step(1'b0, 4'b0100, 1'b0);
        check("pre_rst_gnt", 32'(gnt), 32'h4);
        step(1'b1, 4'b0100, 1'b1);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_ptr", 32'(ptr), 32'h1);

        // Ack while idle is ignored.
        step(1'b0, 4'b0000, 1'b1);
        check("idle_ack_ptr", 32'(ptr), 32'h1);

`ifdef RR_ARB_TIMEOUT_EN
        // Timeout revokes after TIMEOUT cycles of holding.
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) begin
            step(1'b0, 4'b0011, 1'b0);
            check("tmo_hold", 32'(gnt), 32'h1);
        end
        step(1'b0, 4'b0011, 1'b0);
        check("tmo_gnt", 32'(gnt), 32'h2);
        check("tmo_pulse", 32'(timeout), 32'd1);
        check("tmo_ptr", 32'(ptr), 32'h2);
`endif

        // Randomized traffic with sticky requests and occasional reset.
        step(1'b1, 4'b0000, 1'b0);
        cur_req = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) cur_req = N'($urandom_range(0, (1 << N) - 1));
            cur_ack = ($urandom_range(0, 3) == 0);
            cur_rst = ($urandom_range(0, 199) == 0);
            step(cur_rst, cur_req, cur_ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Parametrised round-robin arbiter with registered one-hot grant, grant hold until acknowledge, and back-to-back re-arbitration. It generalises the single rotating priority register in the round-robin arbiter path to N requesters, with a full request/grant/ack handshake, a binary grant index, and optional grant timeout. It sits between N requesters and a single shared resource whose consumer pulses `ack` when it finishes a transfer.

## Interface
- `N`, 4: number of requesters, 2..32.
- `IDW`, `$clog2(N)`: width of `gnt_id` (derived, not overridden).
- `TIMEOUT`, 16: max cycles a grant is held without `ack`; used only with `RR_ARB_TIMEOUT_EN`; 2..65535.

- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in N: request vector, bit i = requester i.
- `ack` in 1: resource consumed current grant; meaningful only while `gnt_valid`=1.
- `gnt` out N: registered one-hot grant, all-zero when idle.
- `gnt_valid` out 1: registered, equals `|gnt`.
- `gnt_id` out IDW: binary index of the set `gnt` bit, 0 when idle.
- `ptr` out N: one-hot priority pointer; set bit is the highest-priority requester.
- `timeout` out 1: one-cycle pulse when a grant is revoked by timeout; constant 0 without the macro.

## Operation
- States: IDLE (`gnt_valid`=0), GRANT (`gnt_valid`=1).
- Arbitration function W(req, ptr): first set bit of `req` scanning from the `ptr` position upward, wrapping from N-1 to 0. Result is one-hot or zero.
- IDLE: if `req`≠0, load `gnt`=W(req, ptr) and go to GRANT. Otherwise stay.
- GRANT, `ack`=1: `ptr` ← `gnt` rotated left by 1 (bit N-1 wraps to bit 0), so the winner becomes lowest priority. In the same edge, `gnt` ← W(req, rotated pointer). Stay in GRANT if the result is nonzero, else go to IDLE. The just-served requester wins again only if it is the sole requester.
- GRANT, `ack`=0, `req[gnt_id]`=0 (requester withdrew): `gnt` ← 0, go to IDLE, `ptr` unchanged.
- GRANT, `ack`=0, `req[gnt_id]`=1: hold `gnt`, `gnt_id`, and `ptr`.
- `ack`=1 and withdrawal in the same cycle: treat as `ack`.
- `ack` while IDLE is ignored.
- `ptr` changes only on `ack` or timeout. It is always exactly one-hot.
- `gnt`, `gnt_id`, and `gnt_valid` always change on the same edge and stay mutually consistent.

## Timing
- Reset values:
  - `ptr`=1 (requester 0 highest).
  - `gnt`=0.
  - `gnt_valid`=0.
  - `gnt_id`=0.
  - `timeout`=0.
  - Hold counter=0.
- `rst` overrides everything on the same edge, including mid-grant. An outstanding grant is dropped without pointer update.
- Request-to-grant latency: `req` sampled at edge k, `gnt` visible after edge k. No combinational path from `req` or `ack` to any output.
- Back-to-back: with continuous requests and `ack` held at 1, a new grant is issued every cycle, rotating in strict round-robin order.
- `ack` is sampled at the edge. A grant visible in cycle c may be acked in cycle c itself.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - A hold counter clears on every new grant load and increments each GRANT cycle without `ack`.
  - When the counter reaches `TIMEOUT`-1 with `ack`=0, the next edge revokes the grant and advances `ptr` exactly as for `ack`, with the same re-arbitration.
  - `timeout`=1 for the single cycle after that edge.
  - `ack` in the same cycle as expiry wins, and `timeout` stays 0.
- `RR_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - `timeout` is tied to 0.
  - A grant is held indefinitely until `ack` or withdrawal.

## Test plan
- Reset then `req`=4'b1111 with `ack`=1 every cycle: `gnt` sequence is 0001, 0010, 0100, 1000, 0001, and `gnt_id` is 0,1,2,3,0.
- `req`=4'b0100 held, `ack`=0 for 5 cycles, then `ack`=1 with `req`=4'b0110: `gnt`=0100 is held for 5 cycles, then `gnt`=0010 on the next edge.
- `req`=4'b1001 from reset with `ptr`=0001, ack once: grants 0001 then 1000. `ptr` becomes 0010 after the first ack and 0001 after the second.
- Granted requester drops `req` with `ack`=0: after the next edge, `gnt`=0 and `gnt_valid`=0, with `ptr` unchanged.
- `rst`=1 asserted while `gnt`=0100: after the edge, all outputs are at their reset values and `ptr`=0001.
- With `RR_ARB_TIMEOUT_EN`, `TIMEOUT`=4, `req`=4'b0011, `ack`=0: `gnt`=0001 for 4 cycles, then `gnt`=0010 with a one-cycle `timeout` pulse and `ptr`=0010.
